// File: rtl/tt_um_micro_seq_checker_if.sv
// Pin bundle shared by the micro tiles: 8-bit sample input and 8-bit status output.
interface tt_um_micro_seq_checker_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    modport master (output ui_in, input uo_out);
    modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/tt_um_micro_seq_checker.sv
// Locks onto an incrementing 8-bit counter stream and counts sequence breaks.
// Build option SEQ_CHK_STICKY_EN turns the error pulse on uo_out[6] into a sticky fail flag.
module tt_um_micro_seq_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tt_um_micro_seq_checker_if.slave      bus
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_COUNT);

    state_t      state, state_nxt;
    logic        rst_n_i;
    logic [7:0]  prev;
    logic        prev_valid;
    logic [7:0]  prev_inc;
    logic        match;
    logic [7:0]  match_cnt, match_cnt_nxt, match_inc;
    logic [7:0]  miss_cnt, miss_cnt_nxt, miss_inc;
    logic [5:0]  err_cnt, err_cnt_nxt;
    logic        err_flag, err_flag_nxt;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'h3F) ? v : v + 6'd1;
    endfunction

    // Release flop: the rest of the design leaves reset one edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_n_i <= 1'b0;
        else        rst_n_i <= 1'b1;
    end

    assign prev_inc  = prev + 8'd1;
    assign match     = prev_valid && (bus.ui_in == prev_inc);
    assign match_inc = match_cnt + 8'd1;
    assign miss_inc  = miss_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= HUNT;
            prev       <= 8'h00;
            prev_valid <= 1'b0;
            match_cnt  <= 8'h00;
            miss_cnt   <= 8'h00;
            err_cnt    <= 6'h00;
            err_flag   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev       <= bus.ui_in;
            prev_valid <= 1'b1;
            match_cnt  <= match_cnt_nxt;
            miss_cnt   <= miss_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
            err_flag   <= err_flag_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        miss_cnt_nxt  = miss_cnt;
        err_cnt_nxt   = err_cnt;
`ifdef SEQ_CHK_STICKY_EN
        err_flag_nxt  = err_flag;
`else
        err_flag_nxt  = 1'b0;
`endif
        unique case (state)
            HUNT: begin
                if (match) begin
                    if (match_inc == LOCK_TGT) begin
                        state_nxt     = LOCKED;
                        match_cnt_nxt = 8'h00;
                        miss_cnt_nxt  = 8'h00;
                    end else begin
                        match_cnt_nxt = match_inc;
                    end
                end else begin
                    match_cnt_nxt = 8'h00;
                end
            end
            LOCKED: begin
                if (match) begin
                    miss_cnt_nxt = 8'h00;
                end else begin
                    // Next compare resyncs to this sample, so one glitch costs one error.
                    err_cnt_nxt  = sat_inc6(err_cnt);
                    err_flag_nxt = 1'b1;
                    if (miss_inc == LOSS_TGT) begin
                        state_nxt     = HUNT;
                        match_cnt_nxt = 8'h00;
                        miss_cnt_nxt  = 8'h00;
                    end else begin
                        miss_cnt_nxt = miss_inc;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    assign bus.uo_out = {state == LOCKED, err_flag, err_cnt};

endmodule

// File: tb/tb_tt_um_micro_seq_checker.sv
// Directed bench: dut_a uses default thresholds, dut_b has LOSS_COUNT=255 for the saturation case.
module tb_tt_um_micro_seq_checker;

`ifdef SEQ_CHK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    int         n_cmp;
    int         n_err;

    tt_um_micro_seq_checker_if bus_a ();
    tt_um_micro_seq_checker_if bus_b ();

    assign bus_a.ui_in = din;
    assign bus_b.ui_in = din;

    tt_um_micro_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    tt_um_micro_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(255)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_uo(input bit locked, input bit flag, input int cnt);
        return {locked, flag, 6'(cnt)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [7:0] d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        din   = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("reset_a", bus_a.uo_out, 8'h00);
        chk("reset_b", bus_b.uo_out, 8'h00);
        repeat (2) @(posedge clk);
        reset_release();

        // Test 1: lock on the edge capturing 0x04
        for (int i = 0; i < 5; i++) begin
            apply(8'(i));
            chk("t1_lock", bus_a.uo_out, (i == 4) ? 8'h80 : 8'h00);
        end

        // Test 2: wrap 0xFF -> 0x00 is a match
        for (int v = 5; v <= 8'hFC; v++) apply(8'(v));
        chk("t2_pre", bus_a.uo_out, 8'h80);
        apply(8'hFD); chk("t2_fd", bus_a.uo_out, 8'h80);
        apply(8'hFE); chk("t2_fe", bus_a.uo_out, 8'h80);
        apply(8'hFF); chk("t2_ff", bus_a.uo_out, 8'h80);
        apply(8'h00); chk("t2_00", bus_a.uo_out, 8'h80);
        apply(8'h01); chk("t2_01", bus_a.uo_out, 8'h80);
        for (int v = 2; v <= 8'h0F; v++) apply(8'(v));

        // Test 3: single glitch costs one error
        apply(8'h10); chk("t3_10", bus_a.uo_out, exp_uo(1, 0, 0));
        apply(8'h11); chk("t3_11", bus_a.uo_out, exp_uo(1, 0, 0));
        apply(8'h55); chk("t3_55", bus_a.uo_out, exp_uo(1, 1, 1));
        apply(8'h56); chk("t3_56", bus_a.uo_out, exp_uo(1, STICKY, 1));
        apply(8'h57); chk("t3_57", bus_a.uo_out, exp_uo(1, STICKY, 1));
        for (int v = 8'h58; v <= 8'hFF; v++) apply(8'(v));
        for (int v = 0; v <= 8'h0F; v++) apply(8'(v));
        chk("t3_bridge", bus_a.uo_out, exp_uo(1, STICKY, 1));

        // Test 4: three misses drop lock; 0x41 is the first match after resync
        apply(8'h10); chk("t4_10", bus_a.uo_out, exp_uo(1, STICKY, 1));
        apply(8'h20); chk("t4_20", bus_a.uo_out, exp_uo(1, 1, 2));
        apply(8'h30); chk("t4_30", bus_a.uo_out, exp_uo(1, 1, 3));
        apply(8'h40); chk("t4_40", bus_a.uo_out, exp_uo(0, 1, 4));
        chk("t4_40_b", bus_b.uo_out, exp_uo(1, 1, 4));
        apply(8'h41); chk("t4_41", bus_a.uo_out, exp_uo(0, STICKY, 4));
        apply(8'h42); chk("t4_42", bus_a.uo_out, exp_uo(0, STICKY, 4));
        apply(8'h43); chk("t4_43", bus_a.uo_out, exp_uo(0, STICKY, 4));
        apply(8'h44); chk("t4_44", bus_a.uo_out, exp_uo(1, STICKY, 4));
        chk("t4_44_b", bus_b.uo_out, exp_uo(1, STICKY, 4));

        // Test 5: dut_b stays locked and its count saturates at 63
        for (int n = 1; n <= 100; n++) begin
            apply(8'hAA);
            chk("t5_sat", bus_b.uo_out, exp_uo(1, 1, (4 + n > 63) ? 63 : 4 + n));
        end

        // Test 6: fresh lock with count 2, then asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst0_a", bus_a.uo_out, 8'h00);
        reset_release();
        for (int i = 0; i < 5; i++) apply(8'(i));
        chk("t6_lock", bus_a.uo_out, 8'h80);
        apply(8'h05); chk("t6_05", bus_a.uo_out, exp_uo(1, 0, 0));
        apply(8'h50); chk("t6_50", bus_a.uo_out, exp_uo(1, 1, 1));
        apply(8'h51); chk("t6_51", bus_a.uo_out, exp_uo(1, STICKY, 1));
        apply(8'h60); chk("t6_60", bus_a.uo_out, exp_uo(1, 1, 2));
        apply(8'h61); chk("t6_61", bus_a.uo_out, exp_uo(1, STICKY, 2));
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_a", bus_a.uo_out, 8'h00);
        chk("t6_async_b", bus_b.uo_out, 8'h00);
        @(posedge clk);
        #1;
        chk("t6_held", bus_a.uo_out, 8'h00);
        reset_release();
        for (int i = 0; i < 5; i++) begin
            apply(8'(i));
            chk("t6_relock", bus_a.uo_out, (i == 4) ? 8'h80 : 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
